// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
package mips_muldiv_pkg;

   localparam int WIDTH = 32;
   localparam int ITER  = WIDTH;
   localparam int CNT_W = $clog2(ITER);

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } state_e;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
      return (is_signed && v[WIDTH-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// Execute-stage bus between the control unit and the multiply/divide unit.
interface mips_muldiv_if;
   import mips_muldiv_pkg::*;

   logic             Start;
   op_e              Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             HiWe;
   logic             LoWe;
   logic [WIDTH-1:0] WData;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   modport master (
      output Start, Op, A, B, HiWe, LoWe, WData,
      input  Busy, Done, HI, LO
   );

   modport slave (
      input  Start, Op, A, B, HiWe, LoWe, WData,
      output Busy, Done, HI, LO
   );

endinterface

// File: rtl/mips_divu_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module mips_divu_step
   import mips_muldiv_pkg::*;
(
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           unused_msb;

   always_comb begin
      shifted = {rem_in, dividend_bit};
      diff    = shifted - {1'b0, divisor};
      q_bit   = (shifted >= {1'b0, divisor});
      // A successful subtract always leaves diff < divisor, so the top bit is zero.
      {unused_msb, rem_out} = q_bit ? diff : shifted;
   end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO, one bit per cycle.
//   state | meaning
//   IDLE  | waiting for Start; MTHI/MTLO writes accepted
//   RUN   | ITER shift-add / restoring-divide iterations
//   FIX   | sign correction and HI/LO write, Done next cycle
module mips_muldiv_unit
   import mips_muldiv_pkg::*;
(
   input  logic          Clk,
   input  logic          Rst_n,
   mips_muldiv_if.slave  bus
);

   state_e             state_q, state_d;
   logic               start_ok;
   logic [CNT_W-1:0]   cnt_q;
   op_e                op_q;
   logic               neg_main_q;
   logic               neg_rem_q;
   logic               b_zero_q;
   logic [WIDTH-1:0]   mag_b_q;
   logic [WIDTH-1:0]   acc_hi_q;
   logic [WIDTH-1:0]   acc_lo_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;

   logic               start_signed;
   logic               start_div;
   logic               is_div;
   logic [WIDTH-1:0]   div_rem;
   logic               div_qbit;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_raw;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   hi_res;
   logic [WIDTH-1:0]   lo_res;

   always_ff @(posedge Clk) begin
      if (!Rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      start_ok = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.Start) begin
               start_ok = 1'b1;
               state_d  = RUN;
            end
         end
         RUN:     if (cnt_q == CNT_W'(ITER-1)) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      start_signed = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
      start_div    = (bus.Op == OP_DIV)  || (bus.Op == OP_DIVU);
      is_div       = (op_q == OP_DIV)    || (op_q == OP_DIVU);
   end

   mips_divu_step u_step (
      .rem_in       (acc_hi_q),
      .dividend_bit (acc_lo_q[WIDTH-1]),
      .divisor      (mag_b_q),
      .rem_out      (div_rem),
      .q_bit        (div_qbit)
   );

   // acc_hi holds the running product high half or the partial remainder;
   // acc_lo holds the multiplier or the dividend/quotient shift register.
   always_comb begin
      mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
      prod_raw = {acc_hi_q, acc_lo_q};
      prod_fix = neg_main_q ? -prod_raw : prod_raw;
      hi_res   = prod_fix[2*WIDTH-1:WIDTH];
      lo_res   = prod_fix[WIDTH-1:0];
      if (is_div) begin
         hi_res = neg_rem_q ? -acc_hi_q : acc_hi_q;
         lo_res = b_zero_q ? '1 : (neg_main_q ? -acc_lo_q : acc_lo_q);
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         cnt_q      <= '0;
         op_q       <= OP_MULT;
         neg_main_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         b_zero_q   <= 1'b0;
         mag_b_q    <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (bus.HiWe) hi_q <= bus.WData;
            if (bus.LoWe) lo_q <= bus.WData;
         end
         if (start_ok) begin
            cnt_q      <= '0;
            op_q       <= bus.Op;
            neg_main_q <= start_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_rem_q  <= start_signed && start_div && bus.A[WIDTH-1];
            b_zero_q   <= (bus.B == '0);
            mag_b_q    <= magnitude(bus.B, start_signed);
            acc_hi_q   <= '0;
            acc_lo_q   <= magnitude(bus.A, start_signed);
         end
         if (state_q == RUN) begin
            cnt_q <= cnt_q + 1'b1;
            if (is_div) begin
               acc_hi_q <= div_rem;
               acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_qbit};
            end else begin
               {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
            end
         end
         if (state_q == FIX) begin
            hi_q   <= hi_res;
            lo_q   <= lo_res;
            done_q <= 1'b1;
         end
      end
   end

   assign bus.Busy = (state_q != IDLE);
   assign bus.Done = done_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed and random checks of mips_muldiv_unit against an arithmetic reference model.
module tb_mips_muldiv_unit;
   import mips_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_hi, exp_lo;

   mips_muldiv_if bus();

   mips_muldiv_unit dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.Start = 1'b0;
      bus.HiWe  = 1'b0;
      bus.LoWe  = 1'b0;
   endtask

   task automatic ref_model(input op_e op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo);
      logic signed [63:0] sa, sb, sp, sq, sr;
      logic [63:0]        up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      hi = '0;
      lo = '0;
      case (op)
         OP_MULT: begin
            sp = sa * sb;
            hi = sp[63:32];
            lo = sp[31:0];
         end
         OP_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            hi = up[63:32];
            lo = up[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               hi = a;
               lo = 32'hFFFF_FFFF;
            end else if (op == OP_DIV) begin
               sq = sa / sb;
               sr = sa % sb;
               hi = sr[31:0];
               lo = sq[31:0];
            end else begin
               hi = a % b;
               lo = a / b;
            end
         end
      endcase
   endtask

   // Launches from just after an edge (possibly the Done cycle of a previous op).
   task automatic run_op(input string tag, input op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic lo_we = 1'b0, input logic [31:0] wd = 32'h0);
      int          lat;
      logic        busy_ok, hold_ok;
      logic [31:0] eh, el, hold_hi, hold_lo;
      ref_model(op, a, b, eh, el);
      bus.Start = 1'b1;
      bus.Op    = op;
      bus.A     = a;
      bus.B     = b;
      bus.LoWe  = lo_we;
      bus.WData = wd;
      tick();
      idle_inputs();
      bus.Op = op_e'($urandom_range(3));
      bus.A  = $urandom;
      bus.B  = $urandom;
      check({tag, "_busy_e0"}, {31'b0, bus.Busy}, 32'd1);
      check({tag, "_done_e0"}, {31'b0, bus.Done}, 32'd0);
      if (lo_we) check({tag, "_lo_mtlo"}, bus.LO, wd);
      hold_hi = lo_we ? exp_hi : bus.HI;
      hold_lo = lo_we ? wd : bus.LO;
      lat = 0;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      while (lat < 40) begin
         tick();
         lat++;
         if (bus.Done) break;
         if (!bus.Busy) busy_ok = 1'b0;
         if (bus.HI !== hold_hi || bus.LO !== hold_lo) hold_ok = 1'b0;
      end
      check({tag, "_latency"}, lat, 32'd33);
      check({tag, "_busy_held"}, {31'b0, busy_ok}, 32'd1);
      check({tag, "_hilo_held"}, {31'b0, hold_ok}, 32'd1);
      check({tag, "_busy_done"}, {31'b0, bus.Busy}, 32'd0);
      check({tag, "_hi"}, bus.HI, eh);
      check({tag, "_lo"}, bus.LO, el);
      exp_hi = eh;
      exp_lo = el;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          dcount, dcycle;
      op_e         rop;
      logic [31:0] ra, rb;

      idle_inputs();
      bus.Op    = OP_MULT;
      bus.A     = '0;
      bus.B     = '0;
      bus.WData = '0;
      exp_hi    = '0;
      exp_lo    = '0;

      rst_n = 1'b0;
      tick();
      tick();
      check("rst_hi",   bus.HI, 32'd0);
      check("rst_lo",   bus.LO, 32'd0);
      check("rst_busy", {31'b0, bus.Busy}, 32'd0);
      check("rst_done", {31'b0, bus.Done}, 32'd0);
      rst_n = 1'b1;
      tick();

      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      tick();
      check("done_one_cycle", {31'b0, bus.Done}, 32'd0);
      run_op("mult_neg", OP_MULT, 32'hFFFF_FFFF, 32'd2);
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div_zero", OP_DIV, 32'h1234_5678, 32'd0);
      run_op("divu_zero", OP_DIVU, 32'h1234_5678, 32'd0);
      run_op("div_zero_neg", OP_DIV, 32'hF000_0001, 32'd0);
      run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000);

      for (int i = 0; i < 24; i++) begin
         rop = op_e'($urandom_range(3));
         ra  = $urandom;
         case ($urandom_range(3))
            0:       rb = $urandom;
            1:       rb = $urandom_range(15);
            2:       rb = 32'd0 - $urandom_range(15);
            default: rb = $urandom >> $urandom_range(31);
         endcase
         run_op("rand", rop, ra, rb);
         if ($urandom_range(1) == 1) tick();
      end

      // Start and MTHI while busy must be ignored.
      bus.Start = 1'b1;
      bus.Op    = OP_MULTU;
      bus.A     = 32'd3;
      bus.B     = 32'd5;
      tick();
      idle_inputs();
      dcount = 0;
      dcycle = 0;
      for (int c = 1; c <= 36; c++) begin
         bus.Start = (c == 10);
         if (c == 10) begin
            bus.Op = OP_DIVU;
            bus.A  = 32'd1000;
            bus.B  = 32'd3;
         end
         bus.HiWe  = (c == 12);
         bus.WData = 32'h0000_DEAD;
         tick();
         if (bus.Done) begin
            dcount++;
            dcycle = c;
         end
      end
      idle_inputs();
      check("ign_done_count", dcount, 32'd1);
      check("ign_done_cycle", dcycle, 32'd33);
      check("ign_busy", {31'b0, bus.Busy}, 32'd0);
      check("ign_hi", bus.HI, 32'd0);
      check("ign_lo", bus.LO, 32'd15);

      // Mid-operation reset aborts without a result.
      bus.Start = 1'b1;
      bus.Op    = OP_MULT;
      bus.A     = $urandom;
      bus.B     = $urandom;
      tick();
      idle_inputs();
      for (int c = 1; c < 20; c++) tick();
      rst_n = 1'b0;
      tick();
      check("abort_busy", {31'b0, bus.Busy}, 32'd0);
      check("abort_done", {31'b0, bus.Done}, 32'd0);
      check("abort_hi", bus.HI, 32'd0);
      check("abort_lo", bus.LO, 32'd0);
      rst_n = 1'b1;
      dcount = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.Done) dcount++;
      end
      check("abort_no_done", dcount, 32'd0);
      exp_hi = '0;
      exp_lo = '0;

      // MTHI / MTLO while idle.
      bus.HiWe  = 1'b1;
      bus.WData = 32'hAAAA_5555;
      #1;
      check("mthi_before_edge", bus.HI, 32'd0);
      tick();
      idle_inputs();
      check("mthi_hi", bus.HI, 32'hAAAA_5555);
      check("mthi_lo", bus.LO, 32'd0);
      bus.LoWe  = 1'b1;
      bus.WData = 32'h0F0F_0F0F;
      tick();
      idle_inputs();
      check("mtlo_lo", bus.LO, 32'h0F0F_0F0F);
      check("mtlo_hi", bus.HI, 32'hAAAA_5555);
      exp_hi = 32'hAAAA_5555;
      exp_lo = 32'h0F0F_0F0F;

      run_op("start_mtlo", OP_MULTU, $urandom, $urandom, 1'b1, 32'h1357_2468);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
